id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Captures decoded operands, register indices, funct fields and the packed control word from the decode stage.
- Presents them to the EX stage, where ex_ctrl[1:0] (ALUOp) and ex_funct drive ALU-control decoding and the ALU.
- Implements hazard-unit stall (hold) and flush (bubble insertion) with a valid bit.

Parameters:
XLEN, 32, datapath width for pc, operands and immediate
CTRL_W, 8, packed control width {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  reset, synchronous and active-low
stall  input  1  hazard unit: hold current contents
flush  input  1  hazard/branch unit: insert bubble
id_valid  input  1  decode stage holds a real instruction
id_pc  input  XLEN  PC of decoded instruction
id_rs1_data  input  XLEN  register-file read data 1
id_rs2_data  input  XLEN  register-file read data 2
id_imm  input  XLEN  sign-extended immediate
id_regs  input  15  {rs1[4:0], rs2[4:0], rd[4:0]}
id_funct  input  10  {funct7[6:0], funct3[2:0]}
id_ctrl  input  CTRL_W  packed control word, bit order as in CTRL_W
ex_valid  output  1  EX stage holds a real instruction
ex_pc  output  XLEN  registered id_pc
ex_rs1_data  output  XLEN  registered id_rs1_data
ex_rs2_data  output  XLEN  registered id_rs2_data
ex_imm  output  XLEN  registered id_imm
ex_regs  output  15  registered id_regs
ex_funct  output  10  registered id_funct
ex_ctrl  output  CTRL_W  registered control word; zero for any bubble

Behaviour:
- Pure register stage; all outputs come directly from flops; latency exactly 1 cycle; no combinational input-to-output path.
- Reset (rst_n=0 at a rising edge): all outputs 0, including ex_valid, ex_ctrl, ex_regs, ex_funct, ex_pc and the data fields.
- Per-edge priority: reset > flush > stall > load.
- flush=1 (stall ignored):
  - ex_valid<=0, ex_ctrl<=0.
  - ex_regs rd field<=0, so forwarding (which ignores rd=x0) cannot match a bubble; rs1/rs2 fields<=0.
  - ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_funct hold their previous values.
- stall=1, flush=0: every output holds its value; the id_* inputs are ignored that cycle.
- Load (stall=0, flush=0): all ex_* <= id_*, ex_valid<=id_valid.
  - If id_valid=0: ex_ctrl<=0 and the ex_regs rd field<=0, i.e. the captured entry is a bubble.
- Bubble control word 0 gives ALUOp=00 (ADD) and no write, memory or branch effect.
- Consecutive stalls hold indefinitely; release resumes the load on the first edge with stall=0.
- Reset asserted mid-stall or mid-flush clears everything on that edge; the first load follows the first edge with rst_n=1.
- No X propagation: every flop has a defined value after the first reset edge.

Optional Feature:
- Macro ID_EX_PERF_EN.
- When defined, two extra output ports are added:
  - perf_bubbles (32b): increments on each edge where flush=1, or where a load captures id_valid=0.
  - perf_stalls (32b): increments on each edge where stall=1 and flush=0.
- Both counters reset to 0 under rst_n=0 and wrap modulo 2^32 with no saturation.
- When the macro is undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all id_*=all-ones -> every ex_* output reads 0; ex_valid=0.
- Load: id_valid=1, id_pc=0x100, id_rs1_data=5, id_imm=0xFFFFFFFC, id_regs={1,2,3}, id_funct={0x20,0}, id_ctrl=0x82 -> one edge later ex_* match exactly, ex_valid=1.
- Stall: after the load above, stall=1 for 3 cycles while id_pc=0x104 -> ex_pc stays 0x100; on the edge after stall drops, ex_pc=0x104.
- Flush over stall: stall=1 and flush=1 together with ex holding pc 0x100 -> ex_valid=0, ex_ctrl=0, ex_regs=0, ex_pc still 0x100.
- Invalid decode: id_valid=0, id_ctrl=0xFF, id_regs rd=7 -> ex_ctrl=0, ex_regs rd field=0, ex_valid=0.
- ID_EX_PERF_EN: 2 flushes, 1 invalid load, 3 stalls, then a counter preloaded to 0xFFFFFFFF taking one more flush -> perf_bubbles=3 and perf_stalls=3 before the wrap; the preloaded counter wraps to 0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands, register indices, funct fields and control.
// Latency: exactly 1 cycle, every output driven straight from a flop, no input-to-output path.
// Backpressure: stall holds all contents; flush inserts a bubble (valid, ctrl and reg indices cleared).
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   stall, flush          hazard-unit hold / bubble insertion (flush wins over stall)
//   id_*                  decode-stage instruction fields, id_valid marks a real instruction
//   ex_*                  registered copies presented to EX; ex_ctrl is zero for any bubble
//   perf_bubbles/_stalls  event counters, present only when ID_EX_PERF_EN is defined
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [14:0]       id_regs,
  input  logic [9:0]        id_funct,
  input  logic [CTRL_W-1:0] id_ctrl,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_stalls,
`endif
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [14:0]       ex_regs,
  output logic [9:0]        ex_funct,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [14:0]       regs_q, regs_d;
  logic [9:0]        funct_q, funct_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    regs_d  = regs_q;
    funct_d = funct_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      // Bubble: data fields keep their old values (harmless, nothing consumes
      // them), but rd=x0 keeps forwarding from matching and ctrl=0 kills effects.
      valid_d = 1'b0;
      ctrl_d  = '0;
      regs_d  = '0;
    end else if (!stall) begin
      valid_d = id_valid;
      pc_d    = id_pc;
      rs1_d   = id_rs1_data;
      rs2_d   = id_rs2_data;
      imm_d   = id_imm;
      regs_d  = id_regs;
      funct_d = id_funct;
      ctrl_d  = id_ctrl;
      if (!id_valid) begin
        ctrl_d      = '0;
        regs_d[4:0] = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      regs_q  <= '0;
      funct_q <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      regs_q  <= regs_d;
      funct_q <= funct_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_q;
  assign ex_rs2_data = rs2_q;
  assign ex_imm      = imm_q;
  assign ex_regs     = regs_q;
  assign ex_funct    = funct_q;
  assign ex_ctrl     = ctrl_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bub_q, bub_d;
  logic [31:0] stl_q, stl_d;

  // Counters wrap naturally modulo 2^32.
  always_comb begin
    bub_d = bub_q;
    stl_d = stl_q;
    if (flush || (!stall && !id_valid)) bub_d = bub_q + 32'd1;
    if (stall && !flush)                stl_d = stl_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bub_q <= '0;
      stl_q <= '0;
    end else begin
      bub_q <= bub_d;
      stl_q <= stl_d;
    end
  end

  assign perf_bubbles = bub_q;
  assign perf_stalls  = stl_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [14:0] regs;
    logic [9:0]  funct;
    logic [7:0]  ctrl;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [14:0] id_regs;
  logic [9:0]  id_funct;
  logic [7:0]  id_ctrl;
  logic ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [14:0] ex_regs;
  logic [9:0]  ex_funct;
  logic [7:0]  ex_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles, perf_stalls;
`endif

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_regs(id_regs),
    .id_funct(id_funct), .id_ctrl(id_ctrl),
`ifdef ID_EX_PERF_EN
    .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_regs(ex_regs),
    .ex_funct(ex_funct), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  ent_t sb[$];
  ent_t model = '0;
  int unsigned m_bub = 0, m_stl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL cyc%0d %s got=%h expected=%h", cyc, name, got, exp);
  endtask

  // Reference: the EX stage holds "the last instruction that was allowed in",
  // with a bubble replacing it whenever it is flushed or the decode slot was empty.
  task automatic drive(input logic r, input logic s, input logic f, input ent_t id);
    @(negedge clk);
    rst_n = r; stall = s; flush = f;
    id_valid = id.v; id_pc = id.pc; id_rs1_data = id.rs1; id_rs2_data = id.rs2;
    id_imm = id.imm; id_regs = id.regs; id_funct = id.funct; id_ctrl = id.ctrl;
    if (!r) begin
      model = '0;
      m_bub = 0; m_stl = 0;
    end else begin
      if (f || (!s && !id.v)) m_bub++;
      if (s && !f) m_stl++;
      if (f) begin
        model.v = 1'b0; model.ctrl = 8'h00; model.regs = 15'h0;
      end else if (!s) begin
        model = id;
        if (!id.v) begin
          model.ctrl = 8'h00;
          model.regs = {id.regs[14:5], 5'd0};
        end
      end
    end
    sb.push_back(model);
  endtask

  // Monitor: every edge presents a new EX entry; compare it to the oldest prediction.
  always @(posedge clk) begin
    ent_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_valid", {31'd0, ex_valid}, {31'd0, e.v});
      chk("sb_pc", ex_pc, e.pc);
      chk("sb_rs1", ex_rs1_data, e.rs1);
      chk("sb_rs2", ex_rs2_data, e.rs2);
      chk("sb_imm", ex_imm, e.imm);
      chk("sb_regs", {17'd0, ex_regs}, {17'd0, e.regs});
      chk("sb_funct", {22'd0, ex_funct}, {22'd0, e.funct});
      chk("sb_ctrl", {24'd0, ex_ctrl}, {24'd0, e.ctrl});
    end
  end

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  ent_t ones, ld, ld2, inv, rnd;

  initial begin
    ones = '1;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    id_valid = 1'b1; id_pc = '1; id_rs1_data = '1; id_rs2_data = '1;
    id_imm = '1; id_regs = '1; id_funct = '1; id_ctrl = '1;

    // Reset with all inputs high
    drive(1'b0, 1'b1, 1'b1, ones);
    drive(1'b0, 1'b0, 1'b0, ones);
    after_edge();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_regs", {17'd0, ex_regs}, 32'd0);
    chk("rst_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("rst_imm", ex_imm, 32'd0);

    // Directed load
    ld = '{v: 1'b1, pc: 32'h100, rs1: 32'd5, rs2: 32'd0, imm: 32'hFFFF_FFFC,
           regs: {5'd1, 5'd2, 5'd3}, funct: {7'h20, 3'h0}, ctrl: 8'h82};
    drive(1'b1, 1'b0, 1'b0, ld);
    after_edge();
    chk("ld_valid", {31'd0, ex_valid}, 32'd1);
    chk("ld_pc", ex_pc, 32'h100);
    chk("ld_imm", ex_imm, 32'hFFFF_FFFC);
    chk("ld_regs", {17'd0, ex_regs}, 32'h0443);
    chk("ld_funct", {22'd0, ex_funct}, 32'h100);
    chk("ld_ctrl", {24'd0, ex_ctrl}, 32'h82);

    // Stall for three cycles with a new instruction waiting
    ld2 = ld; ld2.pc = 32'h104;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, ld2);
    after_edge();
    chk("stall_pc", ex_pc, 32'h100);
    drive(1'b1, 1'b0, 1'b0, ld2);
    after_edge();
    chk("release_pc", ex_pc, 32'h104);

    // Flush wins over stall
    drive(1'b1, 1'b0, 1'b0, ld);
    drive(1'b1, 1'b1, 1'b1, ld2);
    after_edge();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("fl_regs", {17'd0, ex_regs}, 32'd0);
    chk("fl_pc", ex_pc, 32'h100);
    drive(1'b1, 1'b0, 1'b1, ld2);

    // Invalid decode slot becomes a bubble
    inv = ld; inv.v = 1'b0; inv.ctrl = 8'hFF; inv.regs = {5'd1, 5'd2, 5'd7};
    drive(1'b1, 1'b0, 1'b0, inv);
    after_edge();
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("inv_rd", {27'd0, ex_regs[4:0]}, 32'd0);
    chk("inv_rs", {22'd0, ex_regs[14:5]}, {22'd0, 5'd1, 5'd2});

`ifdef ID_EX_PERF_EN
    // Since reset: 2 flushes, 1 invalid load, 3 stalls
    drive(1'b1, 1'b0, 1'b0, ld);
    after_edge();
    chk("perf_bub", perf_bubbles, 32'd3);
    chk("perf_stl", perf_stalls, 32'd3);
`endif

    // Reset in the middle of a stall clears everything
    drive(1'b1, 1'b0, 1'b0, ld);
    drive(1'b1, 1'b1, 1'b0, ld2);
    drive(1'b0, 1'b1, 1'b0, ld2);
    after_edge();
    chk("rst_stall_pc", ex_pc, 32'd0);
    chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rnd.v     = ($urandom_range(0, 3) != 0);
      rnd.pc    = $urandom;
      rnd.rs1   = $urandom;
      rnd.rs2   = $urandom;
      rnd.imm   = $urandom;
      rnd.regs  = 15'($urandom);
      rnd.funct = 10'($urandom);
      rnd.ctrl  = 8'($urandom);
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), rnd);
    end
    drive(1'b1, 1'b0, 1'b0, ld);

`ifdef ID_EX_PERF_EN
    after_edge();
    chk("perf_bub_rnd", perf_bubbles, m_bub);
    chk("perf_stl_rnd", perf_stalls, m_stl);
`endif

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
